// File: rtl/hue_fade_pwm_if.sv
// hue_fade_pwm_if
//   Control and status bundle for the hue_fade_pwm colour-wheel fader.
//   Parameters must match the fader instance:
//     HW       = $clog2(6*SEG_STEPS)
//     DW       = $clog2(PWM_INTERVAL+1)
//     NUM_LEDS = number of RGB LEDs
//
//   Signals (the controller drives the first group, the fader drives the second):
//     run, dir, hue_load, hue_in        -> fader
//     hue, step_tick, duty, pwm         <- fader
//
//   Modports:
//     master - the controller side
//     slave  - the fader side
interface hue_fade_pwm_if #(
  parameter int unsigned HW       = 10,
  parameter int unsigned DW       = 11,
  parameter int unsigned NUM_LEDS = 1
);
  logic                       run;
  logic                       dir;
  logic                       hue_load;
  logic [HW-1:0]              hue_in;
  logic [HW-1:0]              hue;
  logic                       step_tick;
  logic [NUM_LEDS*3*DW-1:0]   duty;
  logic [3*NUM_LEDS-1:0]      pwm;

  modport master (
    output run, dir, hue_load, hue_in,
    input  hue, step_tick, duty, pwm
  );

  modport slave (
    input  run, dir, hue_load, hue_in,
    output hue, step_tick, duty, pwm
  );
endinterface

// File: rtl/hue_fade_pwm.sv
// hue_fade_pwm
//   Multi-LED colour-wheel fader with integrated PWM generators.
//   A hue position moves around a six-segment RGB wheel at a programmable
//   step rate. Each LED's hue is offset from the base hue by a fixed step
//   count, and each LED drives three glitch-free PWM outputs (R/G/B).
//
//   Ports:
//     clk    - system clock, all logic on posedge
//     rst_n  - asynchronous active-low reset
//     bus    - hue_fade_pwm_if.slave:
//                run       1 = step every STEP_INTERVAL cycles, 0 = pause
//                dir       1 = hue increments, 0 = hue decrements
//                hue_load  one-cycle pulse, loads hue_in if < HUE_MAX
//                hue_in    hue to load
//                hue       current base hue (LED 0)
//                step_tick one-cycle pulse per hue step taken
//                duty      active duty values, LED i R/G/B at
//                          [(3i+c)*DW +: DW], c = 0/1/2
//                pwm       pwm[3i+c], c = 0/1/2 for R/G/B of LED i
module hue_fade_pwm #(
  parameter int unsigned PWM_INTERVAL  = 1200,
  parameter int unsigned STEP_INTERVAL = 20000,
  parameter int unsigned SEG_STEPS     = 100,
  parameter int unsigned NUM_LEDS      = 1,
  parameter int unsigned PHASE_OFFSET  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  hue_fade_pwm_if.slave  bus
);

  localparam int unsigned HUE_MAX = 6 * SEG_STEPS;
  localparam int unsigned DW      = $clog2(PWM_INTERVAL + 1);
  localparam int unsigned HW      = $clog2(HUE_MAX);
  localparam int unsigned INC     = PWM_INTERVAL / SEG_STEPS;
  localparam int unsigned SW      = $clog2(STEP_INTERVAL + 1);
  localparam int unsigned NCH     = 3 * NUM_LEDS;

  logic [SW-1:0]          step_cnt_q, step_cnt_d;
  logic [HW-1:0]          hue_q,      hue_d;
  logic                   step_tick_q, step_tick_d;
  logic [DW-1:0]          pwm_cnt_q,  pwm_cnt_d;
  logic [NCH*DW-1:0]      duty_tgt_q, duty_tgt_d;
  logic [NCH*DW-1:0]      duty_q,     duty_d;
  logic [NCH-1:0]         pwm_q,      pwm_d;

  logic load_ok;
  logic step_due;
  logic period_end;

  // R/G/B duty for one LED. The LED's phase offset is a constant per LED,
  // so the modulo on it and the segment/fraction split are constant
  // operations; f*INC is a multiply by a constant.
  function automatic logic [3*DW-1:0] led_duty(input logic [HW-1:0] h,
                                               input int unsigned led);
    int unsigned   hi;
    int unsigned   f;
    logic [DW-1:0] up, dn, r, g, b;
    // Both terms are below HUE_MAX, so one conditional subtract wraps it.
    hi = 32'(h) + (led * PHASE_OFFSET) % HUE_MAX;
    if (hi >= HUE_MAX) hi = hi - HUE_MAX;
    f  = hi % SEG_STEPS;
    up = DW'(f * INC);
    dn = DW'(PWM_INTERVAL) - up;
    r  = '0;
    g  = '0;
    b  = '0;
    case (hi / SEG_STEPS)
      32'd0:   begin r = DW'(PWM_INTERVAL); g = up;                 end
      32'd1:   begin r = dn;                g = DW'(PWM_INTERVAL);  end
      32'd2:   begin g = DW'(PWM_INTERVAL); b = up;                 end
      32'd3:   begin g = dn;                b = DW'(PWM_INTERVAL);  end
      32'd4:   begin r = up;                b = DW'(PWM_INTERVAL);  end
      default: begin r = DW'(PWM_INTERVAL); b = dn;                 end
    endcase
    return {b, g, r};
  endfunction

  assign load_ok    = bus.hue_load && (32'(bus.hue_in) < HUE_MAX);
  assign step_due   = bus.run && (step_cnt_q == SW'(STEP_INTERVAL - 1));
  assign period_end = (pwm_cnt_q == DW'(PWM_INTERVAL - 1));

  // Hue position and step timer. A valid load wins over a coincident step.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    step_cnt_d  = step_cnt_q;
    hue_d       = hue_q;
    step_tick_d = 1'b0;
    if (load_ok) begin
      hue_d      = bus.hue_in;
      step_cnt_d = '0;
    end else if (step_due) begin
      step_cnt_d  = '0;
      step_tick_d = 1'b1;
      if (bus.dir) begin
        hue_d = (hue_q == HW'(HUE_MAX - 1)) ? '0 : hue_q + 1'b1;
      end else begin
        hue_d = (hue_q == '0) ? HW'(HUE_MAX - 1) : hue_q - 1'b1;
      end
    end else if (bus.run) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
  end

  // Duty target from the current hue, active duty swapped in only at the
  // PWM period boundary, and the registered PWM compare.
  always_comb begin
    pwm_cnt_d = period_end ? '0 : pwm_cnt_q + 1'b1;
    duty_d    = period_end ? duty_tgt_q : duty_q;
    for (int l = 0; l < NUM_LEDS; l++) begin
      duty_tgt_d[l*3*DW +: 3*DW] = led_duty(hue_q, l);
    end
    for (int c = 0; c < NCH; c++) begin
      pwm_d[c] = (pwm_cnt_q < duty_q[c*DW +: DW]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q  <= '0;
      hue_q       <= '0;
      step_tick_q <= 1'b0;
      pwm_cnt_q   <= '0;
      duty_tgt_q  <= '0;
      duty_q      <= '0;
      pwm_q       <= '0;
    end else begin
      step_cnt_q  <= step_cnt_d;
      hue_q       <= hue_d;
      step_tick_q <= step_tick_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_tgt_q  <= duty_tgt_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
    end
  end

  assign bus.hue       = hue_q;
  assign bus.step_tick = step_tick_q;
  assign bus.duty      = duty_q;
  assign bus.pwm       = pwm_q;

endmodule

// File: doc/hue_fade_pwm.md
# hue_fade_pwm

- Parametrised multi-LED colour-wheel fader with integrated PWM generators, on one clock domain.
- Moves a hue position around a six-segment RGB wheel at a programmable step rate, with run/pause, direction and hue-load controls.
- Derives per-LED R/G/B duty values, each LED offset in phase by a fixed step count, and drives glitch-free PWM outputs directly to the RGB LED pins.

## Interface
- PWM_INTERVAL, 1200: PWM period in clk cycles; also full-scale duty. Must be a multiple of SEG_STEPS.
- STEP_INTERVAL, 20000: clk cycles between hue steps while running.
- SEG_STEPS, 100: hue steps per 60° segment. HUE_MAX = 6*SEG_STEPS.
- NUM_LEDS, 1: number of RGB LEDs driven.
- PHASE_OFFSET, 0: hue offset, in steps, between LED i and LED i+1. Must be less than HUE_MAX.
- Derived: DW = $clog2(PWM_INTERVAL+1), HW = $clog2(HUE_MAX), INC = PWM_INTERVAL/SEG_STEPS.
- clk  in  1  system clock; single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = hue advances every STEP_INTERVAL cycles; 0 = pause.
- dir  in  1  1 = hue increments; 0 = hue decrements.
- hue_load  in  1  one-cycle pulse; loads hue_in.
- hue_in  in  HW  hue to load; ignored if >= HUE_MAX.
- hue  out  HW  current base hue (LED 0).
- step_tick  out  1  one-cycle pulse per hue step taken.
- duty  out  NUM_LEDS*3*DW  active duty values; LED i R/G/B at slices [(3i+0)*DW +: DW], [(3i+1)*DW +: DW], [(3i+2)*DW +: DW].
- pwm  out  3*NUM_LEDS  pwm[3i+0]=R, pwm[3i+1]=G, pwm[3i+2]=B for LED i.

## Operation
- Step counter, 0..STEP_INTERVAL-1:
  - Advances only while run=1; holds its value while run=0.
  - At terminal count with run=1: counter goes to 0, hue moves ±1 per dir, step_tick=1 in the following cycle.
- Hue wrap: forward from HUE_MAX-1 → 0; backward from 0 → HUE_MAX-1.
- hue_load with valid hue_in: hue ← hue_in and step counter ← 0, no step_tick. hue_load overrides a coincident step.
- Hue for LED i is hi = (hue + i*PHASE_OFFSET) mod HUE_MAX.
- Split hi into segment s = hi/SEG_STEPS and fraction f = hi%SEG_STEPS. Define up = f*INC and dn = PWM_INTERVAL - f*INC.
- Per-segment duty (full scale = PWM_INTERVAL):
  - s0: R=full, G=up, B=0
  - s1: R=dn, G=full, B=0
  - s2: R=0, G=full, B=up
  - s3: R=0, G=dn, B=full
  - s4: R=up, G=0, B=full
  - s5: R=full, G=0, B=dn
- Duty pipeline:
  - duty_tgt is registered from hue every cycle (1-cycle latency).
  - duty (active) loads duty_tgt only on the cycle where pwm_cnt = PWM_INTERVAL-1, so updates never occur mid-period.
- PWM:
  - One shared pwm_cnt, 0..PWM_INTERVAL-1, free-running; it ignores run.
  - pwm output is registered: pwm = (pwm_cnt < duty). duty=0 gives always low; duty=PWM_INTERVAL gives always high.
- No division or multiplication by a variable in hardware: f*INC uses a constant multiply; segment/fraction is tracked alongside hue or computed with constant division.

## Timing
- Reset values: hue=0, step counter=0, pwm_cnt=0, step_tick=0, duty_tgt=0, duty=0, pwm=0.
- After rst_n deasserts, the first nonzero duty appears on the cycle after pwm_cnt first reaches PWM_INTERVAL-1 (PWM_INTERVAL cycles after release).
- Latency from a hue change to duty: 1 cycle to duty_tgt, then up to PWM_INTERVAL cycles to the next period boundary.
- pwm lags the (pwm_cnt, duty) pair by 1 cycle.
- step_tick period is exactly STEP_INTERVAL cycles while run stays 1.
- Pausing (run=0) freezes the step count. Resuming continues the count from the frozen value and does not restart it.
- Asserting rst_n mid-operation immediately forces every register to its reset value, regardless of clock.

## Test plan
Bench parameters: PWM_INTERVAL=12, SEG_STEPS=4, STEP_INTERVAL=5, NUM_LEDS=2, PHASE_OFFSET=8. This gives INC=3 and HUE_MAX=24.

- Reset/idle: release rst_n with run=0 → pwm=0 for 12 cycles. Then LED0 duty R=12, G=0, B=0 with pwm[0] constantly 1; LED1 (hue 8) duty R=0, G=12, B=0.
- Stepping: run=1, dir=1 → step_tick every 5 cycles and hue 0→1. After the next boundary LED0 G=3, and pwm[1] is high for 3 of every 12 cycles.
- Wrap: load hue_in=23, then step forward → hue=0. Load 23 → LED0 duty R=12, G=0, B=3. Load 0, dir=0, step → hue=23.
- Pause: drop run for 20 cycles mid-count → hue and step_tick stay frozen. On resume, the next tick arrives after the remaining count, not after a full 5.
- Load: hue_load hue_in=6 mid-period → duty unchanged until pwm_cnt wraps, then LED0 R=6, G=12, B=0. hue_in=24 → ignored, hue unchanged.
- Async reset: assert rst_n between clock edges while running → all outputs 0 before the next clk edge.
